write_buffer_arb_ctrl: RTL
==========================

WRITE_BUFFER_ARB_CTRL -- requirements
Module: write_buffer_arb_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of producer channels sharing one write buffer; SHALL be >= 2.
REQ-002 Parameter BURST_LEN, default 4: words written per grant; SHALL be >= 1.
REQ-003 Parameter CNT_W, default 2: width of word_idx; SHALL satisfy 2^CNT_W >= BURST_LEN.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 inner_rst  input  1  synchronous, active-high soft clear.
REQ-007 start  input  1  arbitration enable; sampled only in IDLE.
REQ-008 par_done  input  NUM_CH  per-channel one-cycle "partial result ready" pulse.
REQ-009 ready  input  1  write buffer can accept a word this cycle.
REQ-010 write_req  output  1  request to write buffer.
REQ-011 grant  output  NUM_CH  one-hot owner of current transaction; all-zero in IDLE.
REQ-012 write_in_buffer  output  1  word transferred this cycle.
REQ-013 word_idx  output  CNT_W  index of word being written within burst.
REQ-014 stall_output_buffer  output  NUM_CH  per-channel hold for producers.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 overrun  output  1  sticky: a par_done pulse was lost.

Function
REQ-017 Per-channel pending bit SHALL set the cycle after par_done[i] is high.
REQ-018 FSM states SHALL be IDLE, REQ, STALL, WRITE; all outputs SHALL be decoded from registered state only (Moore).
REQ-019 IDLE: if start=1 and any pending set, SHALL latch grant to first pending channel at or after rr_ptr (wrapping NUM_CH-1 -> 0) and go to REQ; else stay.
REQ-020 REQ: write_req=1; ready=1 -> WRITE, ready=0 -> STALL.
REQ-021 STALL: write_req=1; stay while ready=0; ready=1 -> WRITE.
REQ-022 WRITE: write_in_buffer=1 every cycle; word_idx SHALL increment by 1 per cycle with ready=1 starting from 0.
REQ-023 WRITE with ready=0 mid-burst SHALL go to STALL, holding word_idx; return to WRITE resumes at the held word_idx.
REQ-024 WRITE with ready=1 and word_idx=BURST_LEN-1: clear pending[granted], set rr_ptr to granted index +1 (mod NUM_CH), reset word_idx to 0, go to IDLE.
REQ-025 grant SHALL remain constant from REQ entry until IDLE re-entry.
REQ-026 stall_output_buffer[i] SHALL equal pending[i] AND NOT (state=WRITE AND grant[i]).
REQ-027 par_done[i] in the cycle pending[i] is cleared by REQ-024: pending[i] SHALL remain set (new request wins, no overrun).
REQ-028 par_done[i] while pending[i]=1 and not clearing: SHALL set overrun; pending unchanged.
REQ-029 Simultaneous par_done on multiple channels SHALL set all corresponding pending bits in the same cycle.
REQ-030 start=0 SHALL not abort a transaction in progress.
REQ-031 Minimum latency par_done -> first write_in_buffer SHALL be 3 cycles with start=1 and ready=1 (pending, REQ, WRITE).

Reset
REQ-032 rst=1 SHALL immediately force: state IDLE, pending=0, rr_ptr=0, word_idx=0, overrun=0, write_req=0, grant=0, write_in_buffer=0, stall_output_buffer=0, busy=0.
REQ-033 inner_rst=1 at a clock edge SHALL apply the same values as REQ-032, including mid-burst; inner_rst SHALL take priority over all other inputs.

Verification
REQ-034 NUM_CH=4, BURST_LEN=4, start=1, ready=1, par_done=0001 one cycle -> write_req high 1 cycle, write_in_buffer high 4 cycles with word_idx 0,1,2,3, grant=0001, then IDLE.
REQ-035 par_done=1111 in one cycle, ready=1 -> grants served in order 0001, 0010, 0100, 1000; second pass after new par_done=1001 serves 0001 then 1000.
REQ-036 ready=0 during REQ for 3 cycles -> STALL 3 cycles, write_req held 1; ready=0 at word_idx=2 -> STALL, resume at word_idx=2, burst totals 4 transfers.
REQ-037 par_done[1] twice while pending[1] set and idle with start=0 -> overrun=1, single burst later for channel 1; par_done[1] on the burst's final cycle -> second burst, overrun unchanged.
REQ-038 rst asserted asynchronously mid-burst (word_idx=1) and inner_rst asserted in another run -> all outputs zero per REQ-032 (async immediately, sync at next edge), next par_done served from channel 0 pointer.

Source files
------------

// File: rtl/write_buffer_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : write_buffer_arb_ctrl
// Description : Round-robin arbiter granting one of NUM_CH producers a burst
//               of BURST_LEN words into a shared write buffer, with per-channel
//               pending tracking, producer stall generation and sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module write_buffer_arb_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inner_rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] par_done,
    input  logic              ready,
    output logic              write_req,
    output logic [NUM_CH-1:0] grant,
    output logic              write_in_buffer,
    output logic [CNT_W-1:0]  word_idx,
    output logic [NUM_CH-1:0] stall_output_buffer,
    output logic              busy,
    output logic              overrun
);

    localparam int c_PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        STALL = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t              r_state;
    logic [NUM_CH-1:0]   r_pending;
    logic [c_PTR_W-1:0]  r_rr_ptr;
    logic [c_PTR_W-1:0]  r_gidx;

    logic                w_last;
    logic [NUM_CH-1:0]   w_clr;
    logic [NUM_CH-1:0]   w_pend_next;
    logic                w_ovr;
    logic [c_PTR_W-1:0]  w_pick;
    logic [NUM_CH-1:0]   w_onehot;
    logic [c_PTR_W-1:0]  w_rr_next;

    // Burst completion and pending update; a new pulse on the channel being
    // cleared re-arms it instead of counting as an overrun.
    always_comb begin
        w_last      = (r_state == WRITE) && ready && (word_idx == CNT_W'(BURST_LEN - 1));
        w_clr       = w_last ? grant : '0;
        w_pend_next = (r_pending & ~w_clr) | par_done;
        w_ovr       = |(par_done & r_pending & ~w_clr);
        w_rr_next   = (r_gidx == c_PTR_W'(NUM_CH - 1)) ? '0 : r_gidx + c_PTR_W'(1);
    end

    // Round-robin pick: first pending channel at or after the pointer, wrapping.
    always_comb begin : l_scan
        int j;
        w_pick   = '0;
        w_onehot = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = (int'(r_rr_ptr) + k) % NUM_CH;
            if (r_pending[j[c_PTR_W-1:0]]) begin
                w_pick = c_PTR_W'(j);
            end
        end
        w_onehot[w_pick] = 1'b1;
    end

    // Producer hold: pending channels wait unless they are actively writing.
    assign stall_output_buffer = r_pending & ~(((r_state == WRITE) ? grant : '0));

    // Arbitration FSM with registered Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_pending       <= '0;
            r_rr_ptr        <= '0;
            r_gidx          <= '0;
            word_idx        <= '0;
            overrun         <= 1'b0;
            write_req       <= 1'b0;
            grant           <= '0;
            write_in_buffer <= 1'b0;
            busy            <= 1'b0;
        end else if (inner_rst) begin
            r_state         <= IDLE;
            r_pending       <= '0;
            r_rr_ptr        <= '0;
            r_gidx          <= '0;
            word_idx        <= '0;
            overrun         <= 1'b0;
            write_req       <= 1'b0;
            grant           <= '0;
            write_in_buffer <= 1'b0;
            busy            <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            overrun   <= overrun | w_ovr;
            case (r_state)
                IDLE: begin
                    if (start && (|r_pending)) begin
                        r_state   <= REQ;
                        grant     <= w_onehot;
                        r_gidx    <= w_pick;
                        write_req <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                REQ, STALL: begin
                    if (ready) begin
                        r_state         <= WRITE;
                        write_req       <= 1'b0;
                        write_in_buffer <= 1'b1;
                    end else begin
                        r_state <= STALL;
                    end
                end
                WRITE: begin
                    if (!ready) begin
                        r_state         <= STALL;
                        write_req       <= 1'b1;
                        write_in_buffer <= 1'b0;
                    end else if (w_last) begin
                        r_state         <= IDLE;
                        word_idx        <= '0;
                        r_rr_ptr        <= w_rr_next;
                        grant           <= '0;
                        write_in_buffer <= 1'b0;
                        busy            <= 1'b0;
                    end else begin
                        word_idx <= word_idx + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
